// File: rtl/scc_pkg.sv
// rtl/scc_pkg.sv - shared SCC core types and constants used by the fetch unit
package scc_pkg;

   localparam int          INSTR_W          = 32;
   localparam logic [31:0] PC_INC           = 32'd4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DISCARD
   } fetch_state_t;

   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry prefetch FIFO with a registered head entry
module fetch_fifo
   import scc_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  fetch_entry_t  data,
   input  logic          pop,
   input  logic          flush,
   output fetch_entry_t  head,
   output logic          valid,
   output logic [CW-1:0] count
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t  ent [DEPTH];
   logic          do_pop;
   logic [CW-1:0] count_next;
   logic [IW-1:0] wr_idx;

   assign do_pop     = pop & valid;
   assign wr_idx     = IW'(count - CW'(do_pop));
   assign count_next = count + CW'(push) - CW'(do_pop);
   assign head       = ent[0];

   // Entry 0 is the head; a pop shifts live entries down so the head stays a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         valid <= 1'b0;
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      end else if (flush) begin
         count <= '0;
         valid <= 1'b0;
      end else begin
         if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
               if (CW'(i + 1) < count) ent[i] <= ent[i + 1];
            end
         end
         if (push) ent[wr_idx] <= data;
         count <= count_next;
         valid <= (count_next != '0);
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC, fetch FSM and imem request port feeding the decoder
module instr_fetch
   import scc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          DEPTH    = 2
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect,
   input  logic [31:0]        redirect_pc,
   output logic [INSTR_W-1:0] instruction,
   output logic [31:0]        instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = CW + 1;

   fetch_state_t  state;
   logic [31:0]   pc;
   logic [31:0]   pc_inc;
   logic [31:0]   new_pc;
   logic          push;
   logic          pop;
   logic          room;
   logic [CW-1:0] count;
   logic [OW-1:0] occ_next;
   fetch_entry_t  head;

   assign new_pc      = {redirect_pc[31:2], 2'b00};
   assign pc_inc      = pc + PC_INC;
   assign pop         = instr_valid & instr_ready;
   assign push        = (state == WAIT) & imem_ack & ~redirect;
   assign occ_next    = OW'(count) + OW'(push) - OW'(pop);
   assign room        = occ_next < OW'(DEPTH);
   assign instruction = head.instr;
   assign instr_pc    = head.pc;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .data  ('{pc: pc, instr: imem_rdata}),
      .pop   (pop),
      .flush (redirect),
      .head  (head),
      .valid (instr_valid),
      .count (count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
      end else begin
         case (state)
            IDLE: begin
               if (redirect) begin
                  pc        <= new_pc;
                  state     <= WAIT;
                  imem_req  <= 1'b1;
                  imem_addr <= new_pc;
               end else if (room) begin
                  state     <= WAIT;
                  imem_req  <= 1'b1;
                  imem_addr <= pc;
               end
            end
            WAIT, DISCARD: begin
               if (redirect && imem_ack) begin
                  pc        <= new_pc;
                  state     <= WAIT;
                  imem_req  <= 1'b1;
                  imem_addr <= new_pc;
               end else if (redirect) begin
                  // The in-flight request must complete at its old address before refetching.
                  pc    <= new_pc;
                  state <= DISCARD;
               end else if (imem_ack) begin
                  if (state == WAIT) begin
                     pc        <= pc_inc;
                     imem_addr <= pc_inc;
                     state     <= room ? WAIT : IDLE;
                     imem_req  <= room;
                  end else begin
                     imem_addr <= pc;
                     state     <= room ? WAIT : IDLE;
                     imem_req  <= room;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized self-checking bench for instr_fetch against a stream model
module tb_instr_fetch;

   localparam logic [31:0] RST_PC  = 32'h0000_0000;
   localparam logic [31:0] RST_PC2 = 32'hFFFF_FFF8;
   localparam int          DEPTH   = 2;

   typedef struct {
      int          c;
      logic [31:0] pc;
   } dlv_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] instruction;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;

   logic        imem_req2;
   logic [31:0] imem_addr2;
   logic        imem_ack2 = 1'b0;
   logic [31:0] imem_rdata2 = '0;
   logic [31:0] instruction2;
   logic [31:0] instr_pc2;
   logic        instr_valid2;
   logic        instr_ready2 = 1'b1;
   logic        redirect2 = 1'b0;
   logic [31:0] redirect_pc2 = '0;

   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          lat = 0;
   int          ready_mode = 1;
   int          redir_pct = 0;
   bit          rst_req = 1'b0;
   bit          redir_now = 1'b0;
   logic [31:0] redir_val = '0;

   logic [31:0] fetch_pc = RST_PC;
   logic [31:0] exp_pc = RST_PC;
   logic [31:0] exp2 = RST_PC2;
   int          occ = 0;
   int          mem_cnt = 0;
   int          stall = 0;
   bit          stale = 1'b0;

   bit          prev_rst = 1'b1;
   bit          prev_req = 1'b0;
   bit          prev_ack = 1'b0;
   bit          prev_valid = 1'b0;
   bit          prev_ready = 1'b0;
   bit          prev_redir = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [31:0] prev_instr = '0;
   logic [31:0] prev_ipc = '0;

   dlv_t        dlv[$];

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready)
   );

   instr_fetch #(.RESET_PC(RST_PC2), .DEPTH(4)) dut_wrap (
      .clk(clk), .rst(rst),
      .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
      .redirect(redirect2), .redirect_pc(redirect_pc2),
      .instruction(instruction2), .instr_pc(instr_pc2), .instr_valid(instr_valid2),
      .instr_ready(instr_ready2)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0000_FFFF;
         32'h0000_0004: return 32'h0200_EEEE;
         32'h0000_0008: return 32'h0640_0000;
         default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock: check this cycle's outputs, drive this cycle's inputs, advance the model.
   task automatic step();
      bit          rst_d, rd_d, rdy_d, ack, pop;
      logic [31:0] npc;
      @(negedge clk);
      cyc++;
      if (prev_rst) begin
         cyc = 0;
         chk("rst_req", imem_req, 0);
         chk("rst_addr", imem_addr, RST_PC);
         chk("rst_valid", instr_valid, 0);
         chk("rst_instr", instruction, 0);
         chk("rst_ipc", instr_pc, 0);
         chk("rst_addr2", imem_addr2, RST_PC2);
         chk("rst_valid2", instr_valid2, 0);
      end else begin
         chk("valid_vs_model", instr_valid, occ != 0);
         if (prev_req && !prev_ack) begin
            chk("req_held", imem_req, 1);
            chk("addr_held", imem_addr, prev_addr);
         end
         if (prev_valid && !prev_ready && !prev_redir) begin
            chk("instr_stable", instruction, prev_instr);
            chk("ipc_stable", instr_pc, prev_ipc);
         end
      end

      rst_d   = rst_req;
      rst_req = 1'b0;
      rd_d    = !rst_d && (redir_now || (redir_pct > 0 && $urandom_range(0, 99) < redir_pct));
      if (redir_now) npc = redir_val;
      else if ($urandom_range(0, 3) == 0) npc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else npc = $urandom & 32'h0000_0FFF;
      redir_now = 1'b0;
      case (ready_mode)
         0:       rdy_d = 1'b0;
         1:       rdy_d = 1'b1;
         default: rdy_d = 1'($urandom_range(0, 1));
      endcase
      if (!imem_req || rst_d) begin
         ack = 1'b0;
         mem_cnt = 0;
      end else if (lat >= 0 ? mem_cnt >= lat : $urandom_range(0, 2) == 0) begin
         ack = 1'b1;
         mem_cnt = 0;
      end else begin
         ack = 1'b0;
         mem_cnt++;
      end
      rst          = rst_d;
      redirect     = rd_d;
      redirect_pc  = rd_d ? npc : $urandom;
      instr_ready  = rdy_d;
      imem_ack     = ack;
      imem_rdata   = ack ? mem_word(imem_addr) : $urandom;
      imem_ack2    = imem_req2 && !rst_d;
      imem_rdata2  = mem_word(imem_addr2);
      instr_ready2 = 1'b1;

      if (rst_d) begin
         fetch_pc = RST_PC;
         exp_pc   = RST_PC;
         exp2     = RST_PC2;
         occ      = 0;
         stale    = 1'b0;
         stall    = 0;
      end else begin
         if (instr_valid2) begin
            chk("wrap_pc", instr_pc2, exp2);
            chk("wrap_instr", instruction2, mem_word(exp2));
            exp2 += 32'd4;
         end
         pop = instr_valid && rdy_d;
         if (rd_d) begin
            stale    = imem_req && !ack;
            fetch_pc = {npc[31:2], 2'b00};
            exp_pc   = fetch_pc;
            occ      = 0;
         end else begin
            if (pop) begin
               chk("deliver_pc", instr_pc, exp_pc);
               chk("deliver_instr", instruction, mem_word(exp_pc));
               dlv.push_back('{cyc, instr_pc});
               exp_pc += 32'd4;
               occ--;
            end
            if (ack) begin
               if (stale) stale = 1'b0;
               else begin
                  chk("fetch_addr", imem_addr, fetch_pc);
                  fetch_pc += 32'd4;
                  occ++;
               end
            end
         end
         if (rd_d || pop) stall = 0;
         else if (rdy_d) stall++;
         if (stall >= 64) begin
            chk("stall_cycles", stall, 0);
            stall = 0;
         end
      end

      prev_rst   = rst_d;
      prev_req   = imem_req;
      prev_ack   = ack;
      prev_valid = instr_valid;
      prev_ready = rdy_d;
      prev_redir = rd_d;
      prev_addr  = imem_addr;
      prev_instr = instruction;
      prev_ipc   = instr_pc;
   endtask

   initial begin
      int  k0;
      int  bad;
      bit  seen;

      // zero-wait streaming after reset, plus the wrapping instance
      lat = 0; ready_mode = 1;
      step();
      step();
      chk("t1_req_c1", imem_req, 1);
      chk("t1_valid_c1", instr_valid, 0);
      step();
      chk("t1_valid_c2", instr_valid, 1);
      chk("t1_pc_c2", instr_pc, 32'h0);
      chk("t1_ins_c2", instruction, 32'h0000_FFFF);
      chk("t5_pc_c2", instr_pc2, 32'hFFFF_FFF8);
      step();
      chk("t1_pc_c3", instr_pc, 32'h4);
      chk("t1_ins_c3", instruction, 32'h0200_EEEE);
      chk("t5_pc_c3", instr_pc2, 32'hFFFF_FFFC);
      step();
      chk("t1_pc_c4", instr_pc, 32'h8);
      chk("t1_ins_c4", instruction, 32'h0640_0000);
      chk("t5_pc_c4", instr_pc2, 32'h0000_0000);

      // decoder back-pressure from cycle 0
      rst_req = 1; step();
      ready_mode = 0; step();
      repeat (7) step();
      chk("t2_valid", instr_valid, 1);
      chk("t2_head", instr_pc, 32'h0);
      chk("t2_req_low", imem_req, 0);
      chk("t2_addr", imem_addr, 32'h8);
      k0 = cyc; dlv.delete(); ready_mode = 1;
      repeat (4) step();
      chk("t2_count", dlv.size() >= 3, 1);
      if (dlv.size() >= 3) begin
         for (int i = 0; i < 3; i++) begin
            chk("t2_pc", dlv[i].pc, 32'(4 * i));
            chk("t2_cyc", dlv[i].c, k0 + 1 + i);
         end
      end

      // three-cycle memory with redirect while pc 8 is in flight
      rst_req = 1; step();
      lat = 3; ready_mode = 1; seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         step();
         if (imem_req && imem_addr == 32'h8) begin
            seen = 1; redir_now = 1; redir_val = 32'h100; dlv.delete();
         end
      end
      chk("t3_issue_seen", seen, 1);
      repeat (30) step();
      bad = 0;
      foreach (dlv[i]) if (dlv[i].pc == 32'h8) bad++;
      chk("t3_no_pc8", bad, 0);
      chk("t3_delivered", dlv.size() > 0, 1);
      if (dlv.size() > 0) chk("t3_first_pc", dlv[0].pc, 32'h100);

      // redirect coinciding with ack and pop
      rst_req = 1; step();
      lat = 0; ready_mode = 1;
      repeat (6) step();
      redir_now = 1; redir_val = 32'h103;
      step();
      chk("t4_req_at_redir", imem_req, 1);
      chk("t4_valid_at_redir", instr_valid, 1);
      step();
      chk("t4_valid_after", instr_valid, 0);
      chk("t4_addr_after", imem_addr, 32'h100);
      chk("t4_req_after", imem_req, 1);
      step();
      chk("t4_pc_new", instr_pc, 32'h100);

      // reset with the buffer full, then restart
      ready_mode = 0;
      repeat (8) step();
      chk("t6_full_valid", instr_valid, 1);
      chk("t6_full_req", imem_req, 0);
      rst_req = 1; step();
      ready_mode = 1; step();
      chk("t6_rst_valid", instr_valid, 0);
      chk("t6_rst_instr", instruction, 32'h0);
      step(); step();
      chk("t6_restart_pc", instr_pc, RST_PC);

      // randomized traffic
      ready_mode = 2; lat = -1; redir_pct = 3;
      for (int i = 0; i < 4000; i++) begin
         if (i % 500 == 0) lat = int'($urandom_range(0, 3)) - 1;
         if (i % 700 == 699) rst_req = 1;
         step();
      end
      redir_pct = 0; ready_mode = 1; lat = 0;
      repeat (40) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
